// File: rtl/cmd_matcher.sv
// Line-buffered command matcher: collects bytes up to a terminator, compares the line against four keywords, and answers with a pulse plus "<id|?>\r".
// Optional CMD_MATCH_NOCASE_EN folds upper-case input letters to lower case before buffering.
module cmd_matcher #(
  parameter int unsigned          MAX_LEN = 8,
  parameter logic [7:0]           TERM    = 8'h0D,
  parameter logic [MAX_LEN*8-1:0] KW0     = 64'h0000_0073_7461_7274, // "start"
  parameter logic [MAX_LEN*8-1:0] KW1     = 64'h0000_0000_7374_6F70, // "stop"
  parameter logic [MAX_LEN*8-1:0] KW2     = 64'h0000_0068_6974_737A, // "hitsz"
  parameter logic [MAX_LEN*8-1:0] KW3     = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       cmd_hit,
  output logic       cmd_miss,
  output logic [1:0] cmd_id
);

  localparam int unsigned BW = MAX_LEN * 8;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_RECV    = 2'd0;
  localparam logic [1:0] S_MATCH   = 2'd1;
  localparam logic [1:0] S_RESP_ID = 2'd2;
  localparam logic [1:0] S_RESP_CR = 2'd3;

  logic [1:0]    r_state;
  logic [BW-1:0] r_buf;
  logic [LW-1:0] r_len;
  logic          r_ovf;
  logic          r_in_ready;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_cmd_hit;
  logic          r_cmd_miss;
  logic [1:0]    r_cmd_id;

  logic [1:0]    w_state_nxt;
  logic [BW-1:0] w_buf_nxt;
  logic [LW-1:0] w_len_nxt;
  logic          w_ovf_nxt;
  logic          w_in_ready_nxt;
  logic          w_tx_valid_nxt;
  logic [7:0]    w_tx_data_nxt;
  logic          w_cmd_hit_nxt;
  logic          w_cmd_miss_nxt;
  logic [1:0]    w_cmd_id_nxt;

  logic          w_accept;
  logic [7:0]    w_byte;
  logic [3:0]    w_hit;
  logic          w_any_hit;
  logic [1:0]    w_hit_id;

  assign w_accept = in_valid & r_in_ready;

`ifdef CMD_MATCH_NOCASE_EN
  assign w_byte = ((in_data >= 8'h41) && (in_data <= 8'h5A)) ? (in_data + 8'h20) : in_data;
`else
  assign w_byte = in_data;
`endif

  // Disabled (all-zero) keyword slots never match; an overflowed line never matches.
  assign w_hit[0] = (r_buf == KW0) & (KW0 != '0) & ~r_ovf;
  assign w_hit[1] = (r_buf == KW1) & (KW1 != '0) & ~r_ovf;
  assign w_hit[2] = (r_buf == KW2) & (KW2 != '0) & ~r_ovf;
  assign w_hit[3] = (r_buf == KW3) & (KW3 != '0) & ~r_ovf;
  assign w_any_hit = |w_hit;

  always_comb begin
    w_hit_id = 2'd3;
    if (w_hit[2]) w_hit_id = 2'd2;
    if (w_hit[1]) w_hit_id = 2'd1;
    if (w_hit[0]) w_hit_id = 2'd0;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_buf_nxt      = r_buf;
    w_len_nxt      = r_len;
    w_ovf_nxt      = r_ovf;
    w_in_ready_nxt = r_in_ready;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_cmd_hit_nxt  = 1'b0;
    w_cmd_miss_nxt = 1'b0;
    w_cmd_id_nxt   = r_cmd_id;

    case (r_state)
      S_RECV: begin
        if (w_accept) begin
          if (in_data == TERM) begin
            if (r_len != '0) begin
              w_state_nxt    = S_MATCH;
              w_in_ready_nxt = 1'b0;
            end
          end else if ((in_data != 8'h00) && (in_data != 8'h0A)) begin
            if (r_len == LW'(MAX_LEN)) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_buf_nxt = {r_buf[BW-9:0], w_byte};
              w_len_nxt = LW'(r_len + 1'b1);
            end
          end
        end
      end
      S_MATCH: begin
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = S_RESP_ID;
        if (w_any_hit) begin
          w_cmd_hit_nxt = 1'b1;
          w_cmd_id_nxt  = w_hit_id;
          w_tx_data_nxt = {6'b001100, w_hit_id};
        end else begin
          w_cmd_miss_nxt = 1'b1;
          w_tx_data_nxt  = 8'h3F;
        end
      end
      S_RESP_ID: begin
        if (tx_ready) begin
          w_tx_data_nxt = 8'h0D;
          w_state_nxt   = S_RESP_CR;
        end
      end
      S_RESP_CR: begin
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_in_ready_nxt = 1'b1;
          w_buf_nxt      = '0;
          w_len_nxt      = '0;
          w_ovf_nxt      = 1'b0;
          w_state_nxt    = S_RECV;
        end
      end
      default: begin
        w_state_nxt    = S_RECV;
        w_in_ready_nxt = 1'b1;
        w_tx_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_RECV;
      r_buf      <= '0;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_cmd_hit  <= 1'b0;
      r_cmd_miss <= 1'b0;
      r_cmd_id   <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_buf      <= w_buf_nxt;
      r_len      <= w_len_nxt;
      r_ovf      <= w_ovf_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_cmd_hit  <= w_cmd_hit_nxt;
      r_cmd_miss <= w_cmd_miss_nxt;
      r_cmd_id   <= w_cmd_id_nxt;
    end
  end

  assign in_ready = r_in_ready;
  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign cmd_hit  = r_cmd_hit;
  assign cmd_miss = r_cmd_miss;
  assign cmd_id   = r_cmd_id;

endmodule

// File: tb/tb_cmd_matcher.sv
// Self-checking bench for cmd_matcher: directed vector table, reset-in-response sequence, randomized lines against a string-level model.
module tb_cmd_matcher;

  typedef logic [7:0] u8_t;

  localparam int unsigned MAX_LEN = 8;
  localparam u8_t         TERM    = 8'h0D;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       cmd_hit;
  logic       cmd_miss;
  logic [1:0] cmd_id;

  cmd_matcher dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .cmd_hit  (cmd_hit),
    .cmd_miss (cmd_miss),
    .cmd_id   (cmd_id)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  hit_cnt = 0;
  int  miss_cnt = 0;
  int  pulse_cyc = -1;
  u8_t txq[$];
  bit  prev_stall = 1'b0;
  bit  prev_rst = 1'b0;
  u8_t prev_data = 8'h00;

  string kw_s[4] = '{"start", "stop", "hitsz", ""};

  typedef struct {
    string      line;
    int         stall;
    bit         resp;
    bit         hit;
    logic [1:0] id;
    u8_t        tx0;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: pulses, completed tx transfers, and hold stability under backpressure.
  always @(negedge clk) begin
    if (prev_stall && prev_rst && rst) begin
      check("tx hold valid", 32'(tx_valid), 32'd1);
      check("tx hold data", 32'(tx_data), 32'(prev_data));
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_rst   = rst;
    if (cmd_hit === 1'b1) begin hit_cnt++; pulse_cyc = cyc; end
    if (cmd_miss === 1'b1) begin miss_cnt++; pulse_cyc = cyc; end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
  end

  function automatic void str2q(input string s, output u8_t q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(u8_t'(s[i]));
  endfunction

  // Reference: build the line as a character list, then compare whole strings.
  function automatic void model(input u8_t b[$], output bit resp, output bit hit, output logic [1:0] id);
    u8_t line[$];
    bit  ovf = 1'b0;
    hit = 1'b0;
    id  = 2'd0;
    foreach (b[i]) begin
      u8_t c = b[i];
      if (c == 8'h00 || c == 8'h0A) continue;
`ifdef CMD_MATCH_NOCASE_EN
      if (c >= "A" && c <= "Z") c = c + 8'h20;
`endif
      if (line.size() == MAX_LEN) ovf = 1'b1;
      else line.push_back(c);
    end
    resp = (line.size() > 0);
    for (int k = 0; k < 4; k++) begin
      bit eq = (kw_s[k].len() > 0) && (kw_s[k].len() == line.size()) && !ovf;
      if (eq) for (int j = 0; j < line.size(); j++) if (u8_t'(kw_s[k][j]) != line[j]) eq = 1'b0;
      if (eq && !hit) begin hit = 1'b1; id = 2'(k); end
    end
  endfunction

  task automatic send_byte(input u8_t b);
    int n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    if (!in_ready) check("in_ready wait timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic do_line(input u8_t b[$], input int stall, input bit exp_resp, input bit exp_hit,
                         input logic [1:0] exp_id, input u8_t exp_tx0, input string nm);
    int h0 = hit_cnt;
    int m0 = miss_cnt;
    int k;
    int n;
    txq.delete();
    tx_ready = (stall == 0);
    foreach (b[i]) send_byte(b[i]);
    send_byte(TERM);
    k = cyc;
    if (!exp_resp) begin
      repeat (5) step();
      check({nm, " idle in_ready"}, 32'(in_ready), 32'd1);
      check({nm, " idle tx_valid"}, 32'(tx_valid), 32'd0);
    end else if (stall == 0) begin
      check({nm, " in_ready low k"}, 32'(in_ready), 32'd0);
      step();
      check({nm, " tx_valid k+1"}, 32'(tx_valid), 32'd1);
      step();
      check({nm, " in_ready low k+2"}, 32'(in_ready), 32'd0);
      step();
      check({nm, " in_ready back k+3"}, 32'(in_ready), 32'd1);
      check({nm, " pulse cycle"}, 32'(pulse_cyc), 32'(k + 1));
    end else begin
      n = 0;
      while (!tx_valid && n < 50) begin step(); n++; end
      check({nm, " tx_valid rise"}, 32'(tx_valid), 32'd1);
      repeat (stall) begin
        check({nm, " stall in_ready"}, 32'(in_ready), 32'd0);
        check({nm, " stall tx_data"}, 32'(tx_data), 32'(exp_tx0));
        step();
      end
      tx_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      check({nm, " in_ready return"}, 32'(in_ready), 32'd1);
    end
    step();
    check({nm, " hit pulses"}, 32'(hit_cnt - h0), 32'(exp_resp && exp_hit));
    check({nm, " miss pulses"}, 32'(miss_cnt - m0), 32'(exp_resp && !exp_hit));
    check({nm, " cmd_id"}, 32'(cmd_id), 32'(exp_id));
    check({nm, " tx count"}, 32'(txq.size()), exp_resp ? 32'd2 : 32'd0);
    if (exp_resp && txq.size() == 2) begin
      check({nm, " tx byte0"}, 32'(txq[0]), 32'(exp_tx0));
      check({nm, " tx byte1"}, 32'(txq[1]), 32'h0D);
    end
    tx_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    u8_t        q[$];
    bit         r_resp;
    bit         r_hit;
    logic [1:0] r_id;
    logic [1:0] mid;
    int         h0;
    int         m0;

    vecs[0]  = '{"start",     0,  1'b1, 1'b1, 2'd0, 8'h30};
    vecs[1]  = '{"hitsz",     20, 1'b1, 1'b1, 2'd2, 8'h32};
    vecs[2]  = '{"xyz",       0,  1'b1, 1'b0, 2'd2, 8'h3F};
    vecs[3]  = '{"sto",       0,  1'b1, 1'b0, 2'd2, 8'h3F};
    vecs[4]  = '{"stopstopx", 0,  1'b1, 1'b0, 2'd2, 8'h3F};
    vecs[5]  = '{"stop",      0,  1'b1, 1'b1, 2'd1, 8'h31};
    vecs[6]  = '{"",          0,  1'b0, 1'b0, 2'd1, 8'h00};
    vecs[7]  = '{"\n",        0,  1'b0, 1'b0, 2'd1, 8'h00};
`ifdef CMD_MATCH_NOCASE_EN
    vecs[8]  = '{"STOP",      0,  1'b1, 1'b1, 2'd1, 8'h31};
`else
    vecs[8]  = '{"STOP",      0,  1'b1, 1'b0, 2'd1, 8'h3F};
`endif
    vecs[9]  = '{"stopp",     0,  1'b1, 1'b0, 2'd1, 8'h3F};
    vecs[10] = '{"hitsz",     3,  1'b1, 1'b1, 2'd2, 8'h32};
    vecs[11] = '{"stopstop",  0,  1'b1, 1'b0, 2'd2, 8'h3F};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) step();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset tx_valid", 32'(tx_valid), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'h00);
    check("reset cmd_hit", 32'(cmd_hit), 32'd0);
    check("reset cmd_miss", 32'(cmd_miss), 32'd0);
    check("reset cmd_id", 32'(cmd_id), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      str2q(vecs[i].line, q);
      do_line(q, vecs[i].stall, vecs[i].resp, vecs[i].hit, vecs[i].id, vecs[i].tx0,
              $sformatf("vec%0d", i));
    end

    // Reset while the ID byte is stalled: response abandoned, outputs back to reset values.
    tx_ready = 1'b0;
    str2q("stop", q);
    foreach (q[i]) send_byte(q[i]);
    send_byte(TERM);
    repeat (4) step();
    check("pre-reset tx_valid", 32'(tx_valid), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst tx_valid", 32'(tx_valid), 32'd0);
    check("midrst tx_data", 32'(tx_data), 32'h00);
    check("midrst cmd_hit", 32'(cmd_hit), 32'd0);
    check("midrst cmd_miss", 32'(cmd_miss), 32'd0);
    check("midrst cmd_id", 32'(cmd_id), 32'd0);
    h0 = hit_cnt;
    m0 = miss_cnt;
    txq.delete();
    tx_ready = 1'b1;
    repeat (6) step();
    check("postrst no pulse", 32'(hit_cnt + miss_cnt - h0 - m0), 32'd0);
    check("postrst no tx", 32'(txq.size()), 32'd0);
    str2q("stop", q);
    do_line(q, 0, 1'b1, 1'b1, 2'd1, 8'h31, "postrst stop");

    // Randomized lines against the string-level model.
    mid = 2'd1;
    for (int t = 0; t < 60; t++) begin
      string alpha = "abehiopqrstxzSTOP";
      q.delete();
      if ($urandom_range(0, 2) != 0) begin
        str2q(kw_s[$urandom_range(0, 2)], q);
        case ($urandom_range(0, 4))
          1: q.push_back(u8_t'(alpha[$urandom_range(0, alpha.len() - 1)]));
          2: void'(q.pop_back());
          3: begin
            int p = $urandom_range(0, q.size() - 1);
            q[p] = q[p] - 8'h20;
          end
          4: q.insert($urandom_range(0, q.size()), ($urandom_range(0, 1) != 0) ? 8'h0A : 8'h00);
          default: ;
        endcase
      end else begin
        int len = $urandom_range(0, 11);
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 9) == 0) q.push_back(($urandom_range(0, 1) != 0) ? 8'h0A : 8'h00);
          else q.push_back(u8_t'(alpha[$urandom_range(0, alpha.len() - 1)]));
        end
      end
      model(q, r_resp, r_hit, r_id);
      if (r_resp && r_hit) mid = r_id;
      do_line(q, $urandom_range(0, 3), r_resp, r_hit, mid,
              r_hit ? (8'h30 + u8_t'(r_id)) : 8'h3F, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
